// File: rtl/spi_master_mc.sv
// spi_master_mc: register-mapped SPI master with multiple chip selects.
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   addr, wdata, we, re   register bus (0 CTRL, 1 TXDATA, 2 RXDATA, 3 STATUS)
//   rdata                 read data, combinational from addr, zero-extended
//   busy                  high while a transfer is in progress
//   spi_clk, spi_mosi     serial clock and data out
//   spi_miso              serial data in
//   spi_cs_n              active-low chip selects
module spi_master_mc #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CS = 4,
    parameter int unsigned DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    input  logic              re,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs_n
);
    localparam int unsigned HALF_W = $clog2(2 * DATA_W);
    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_TX   = 2'd1;
    localparam logic [1:0] A_RX   = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, SHIFT = 2'd2, FINISH = 2'd3} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [DATA_W-1:0]   tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d, overrun_q, overrun_d;
    logic                mosi_q, mosi_d, sclk_q, sclk_d, busy_q, busy_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    // Software-visible CTRL fields
    logic [DIV_W-1:0]    div_q, div_d;
    logic                cpol_q, cpol_d, cpha_q, cpha_d, cs_hold_q, cs_hold_d;
    logic [3:0]          cs_idx_q, cs_idx_d;
    // Per-transfer snapshot of CTRL
    logic [DIV_W-1:0]    xdiv_q, xdiv_d;
    logic                xcpha_q, xcpha_d, xhold_q, xhold_d;
    logic [3:0]          xidx_q, xidx_d;

    logic wr_ctrl, wr_tx, wr_stat, rd_rx, t_done, shift_ev, sample_ev;
    logic [31:0] ctrl_rd;
    logic unused_wdata;

    assign unused_wdata = ^wdata;

    // One-hot active-low decode; out-of-range index selects nothing
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [3:0] idx);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (idx == 4'(i)) v[i] = 1'b0;
        end
        return v;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            half_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            mosi_q     <= 1'b0;
            sclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            cs_n_q     <= '1;
            div_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            cs_hold_q  <= 1'b0;
            cs_idx_q   <= '0;
            xdiv_q     <= '0;
            xcpha_q    <= 1'b0;
            xhold_q    <= 1'b0;
            xidx_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            mosi_q     <= mosi_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
            cs_n_q     <= cs_n_d;
            div_q      <= div_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            cs_hold_q  <= cs_hold_d;
            cs_idx_q   <= cs_idx_d;
            xdiv_q     <= xdiv_d;
            xcpha_q    <= xcpha_d;
            xhold_q    <= xhold_d;
            xidx_q     <= xidx_d;
        end
    end

    // Next-state, register file and shift control
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        half_d     = half_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        mosi_d     = mosi_q;
        sclk_d     = sclk_q;
        busy_d     = busy_q;
        cs_n_d     = cs_n_q;
        div_d      = div_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        cs_hold_d  = cs_hold_q;
        cs_idx_d   = cs_idx_q;
        xdiv_d     = xdiv_q;
        xcpha_d    = xcpha_q;
        xhold_d    = xhold_q;
        xidx_d     = xidx_q;
        shift_ev   = 1'b0;
        sample_ev  = 1'b0;

        wr_ctrl = we && (addr == A_CTRL);
        wr_tx   = we && (addr == A_TX);
        wr_stat = we && (addr == A_STAT);
        rd_rx   = re && (addr == A_RX);
        t_done  = (cnt_q == xdiv_q);

        if (rd_rx) rx_valid_d = 1'b0;
        if (wr_stat && wdata[2]) overrun_d = 1'b0;
        if ((state_q != IDLE) && (wr_ctrl || wr_tx)) overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                sclk_d = cpol_q;
                if (wr_ctrl) begin
                    div_d     = wdata[DIV_W-1:0];
                    cpol_d    = wdata[16];
                    cpha_d    = wdata[17];
                    cs_idx_d  = wdata[23:20];
                    cs_hold_d = wdata[24];
                    sclk_d    = wdata[16];
                    // Release a held CS when hold drops or the target changes
                    if (!wdata[24] || (wdata[23:20] != xidx_q)) cs_n_d = '1;
                end else if (wr_tx) begin
                    state_d = ASSERT;
                    busy_d  = 1'b1;
                    xdiv_d  = div_q;
                    xcpha_d = cpha_q;
                    xhold_d = cs_hold_q;
                    xidx_d  = cs_idx_q;
                    cs_n_d  = cs_decode(cs_idx_q);
                    rx_d    = '0;
                    // cpha=0 presents the MSB before the first clock edge
                    if (!cpha_q) begin
                        mosi_d = wdata[DATA_W-1];
                        tx_d   = {wdata[DATA_W-2:0], 1'b0};
                    end else begin
                        tx_d   = wdata[DATA_W-1:0];
                    end
                end
            end
            ASSERT: begin
                cnt_d = cnt_q + DIV_W'(1);
                if (t_done) begin
                    cnt_d     = '0;
                    state_d   = SHIFT;
                    half_d    = '0;
                    sclk_d    = ~sclk_q;
                    shift_ev  = xcpha_q;
                    sample_ev = ~xcpha_q;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + DIV_W'(1);
                if (t_done) begin
                    cnt_d = '0;
                    if (half_q == HALF_W'(2 * DATA_W - 1)) begin
                        state_d = FINISH;
                    end else begin
                        half_d = half_q + HALF_W'(1);
                        sclk_d = ~sclk_q;
                        // Odd current half means the next edge is a leading one
                        if (half_q[0]) begin
                            shift_ev  = xcpha_q;
                            sample_ev = ~xcpha_q;
                        end else begin
                            shift_ev  = ~xcpha_q;
                            sample_ev = xcpha_q;
                        end
                    end
                end
            end
            FINISH: begin
                cnt_d = cnt_q + DIV_W'(1);
                if (t_done) begin
                    cnt_d      = '0;
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    rx_data_d  = rx_q;
                    rx_valid_d = 1'b1;
                    if (rx_valid_q) overrun_d = 1'b1;
                    if (!xhold_q) cs_n_d = '1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (shift_ev) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end
        if (sample_ev) rx_d = {rx_q[DATA_W-2:0], spi_miso};
    end

    // Register read mux
    always_comb begin
        ctrl_rd            = '0;
        ctrl_rd[DIV_W-1:0] = div_q;
        ctrl_rd[16]        = cpol_q;
        ctrl_rd[17]        = cpha_q;
        ctrl_rd[23:20]     = cs_idx_q;
        ctrl_rd[24]        = cs_hold_q;
        rdata              = '0;
        case (addr)
            A_CTRL:  rdata = ctrl_rd;
            A_TX:    rdata = '0;
            A_RX:    rdata = 32'(rx_data_q);
            default: rdata = {29'd0, overrun_q, rx_valid_q, busy_q};
        endcase
    end

    assign busy     = busy_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed self-checking bench for spi_master_mc (DATA_W=8, NUM_CS=4, DIV_W=8).
module tb_spi_master_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic        busy;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso;
    logic [3:0]  spi_cs_n;
    logic        loop_en = 1'b0;
    logic        miso_tie = 1'b0;

    int tests = 0;
    int failed = 0;

    assign spi_miso = loop_en ? spi_mosi : miso_tie;

    spi_master_mc #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .busy(busy), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic pulse, output logic [31:0] d);
        addr = a; re = pulse;
        #1;
        d = rdata;
        cyc();
        re = 1'b0;
    endtask

    // Start a transfer and follow it until busy drops (bounded).
    task automatic run(input logic [7:0] data, input logic [3:0] cs_exp,
                       input int rd_at, input int wr_at,
                       output int n, output int pulses, output logic cs_ok);
        logic prev;
        wr(2'd1, {24'd0, data});
        n = 1; pulses = 0;
        prev = spi_clk;
        cs_ok = busy && (spi_cs_n === cs_exp);
        while (n < 1000) begin
            if (n == rd_at) begin addr = 2'd2; re = 1'b1; end
            if (n == wr_at) begin addr = 2'd1; wdata = 32'hFF; we = 1'b1; end
            cyc();
            re = 1'b0; we = 1'b0;
            if (!busy) break;
            n++;
            if (spi_cs_n !== cs_exp) cs_ok = 1'b0;
            if (!prev && spi_clk) pulses++;
            prev = spi_clk;
        end
    endtask

    initial begin
        logic [31:0] d;
        int n, pulses;
        logic cs_ok;

        // Reset state
        repeat (3) cyc();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cs", 32'(spi_cs_n), 32'hF);
        check("rst_sclk", 32'(spi_clk), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        rd(2'd0, 1'b0, d); check("rst_ctrl", d, 32'd0);
        rd(2'd2, 1'b0, d); check("rst_rx", d, 32'd0);
        rd(2'd3, 1'b0, d); check("rst_status", d, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Mode 0, div=1, cs 2, loopback 0xA5
        wr(2'd0, 32'h0020_0001);
        rd(2'd0, 1'b0, d); check("ctrl_readback", d, 32'h0020_0001);
        loop_en = 1'b1;
        run(8'hA5, 4'b1011, 0, 0, n, pulses, cs_ok);
        check("m0_busy_len", 32'(n), 32'd36);
        check("m0_pulses", 32'(pulses), 32'd8);
        check("m0_cs", 32'(cs_ok), 32'd1);
        check("m0_cs_after", 32'(spi_cs_n), 32'hF);
        rd(2'd2, 1'b0, d); check("m0_rx", d, 32'hA5);
        rd(2'd3, 1'b0, d); check("m0_status", d, 32'h2);
        rd(2'd2, 1'b1, d);
        rd(2'd3, 1'b0, d); check("m0_status_rdclr", d, 32'h0);

        // Mode 3, div=0, cs 0, MISO tied high, 0x3C
        wr(2'd0, 32'h0003_0000);
        check("m3_sclk_idle", 32'(spi_clk), 32'd1);
        loop_en = 1'b0; miso_tie = 1'b1;
        run(8'h3C, 4'b1110, 0, 0, n, pulses, cs_ok);
        check("m3_busy_len", 32'(n), 32'd18);
        check("m3_pulses", 32'(pulses), 32'd8);
        check("m3_cs", 32'(cs_ok), 32'd1);
        check("m3_sclk_after", 32'(spi_clk), 32'd1);
        rd(2'd2, 1'b1, d); check("m3_rx", d, 32'hFF);

        // TXDATA write during busy is dropped and flags overrun
        wr(2'd0, 32'h0010_0001);
        loop_en = 1'b1; miso_tie = 1'b0;
        run(8'h5A, 4'b1101, 0, 5, n, pulses, cs_ok);
        check("ovr_busy_len", 32'(n), 32'd36);
        check("ovr_cs", 32'(cs_ok), 32'd1);
        rd(2'd2, 1'b0, d); check("ovr_rx", d, 32'h5A);
        rd(2'd3, 1'b0, d); check("ovr_status", d, 32'h6);
        wr(2'd3, 32'h4);
        rd(2'd3, 1'b0, d); check("ovr_clear", d, 32'h2);
        rd(2'd2, 1'b1, d);

        // cs_hold across two back-to-back transfers, no RXDATA read between
        wr(2'd0, 32'h0130_0000);
        run(8'h11, 4'b0111, 0, 0, n, pulses, cs_ok);
        check("hold1_cs", 32'(cs_ok), 32'd1);
        cyc(); cyc();
        check("hold_idle_cs", 32'(spi_cs_n), 32'h7);
        run(8'h22, 4'b0111, 0, 0, n, pulses, cs_ok);
        check("hold2_cs", 32'(cs_ok), 32'd1);
        check("hold2_cs_after", 32'(spi_cs_n), 32'h7);
        rd(2'd2, 1'b0, d); check("hold2_rx", d, 32'h22);
        rd(2'd3, 1'b0, d); check("hold2_status", d, 32'h6);
        wr(2'd0, 32'h0030_0000);
        check("hold_release", 32'(spi_cs_n), 32'hF);

        // RXDATA read coincident with the completing edge: set wins
        wr(2'd3, 32'h4);
        rd(2'd2, 1'b1, d);
        rd(2'd3, 1'b0, d); check("coin_pre_status", d, 32'h0);
        run(8'h77, 4'b0111, 18, 0, n, pulses, cs_ok);
        check("coin_busy_len", 32'(n), 32'd18);
        rd(2'd3, 1'b0, d); check("coin_status", d, 32'h2);
        rd(2'd2, 1'b0, d); check("coin_rx", d, 32'h77);

        // Reset at cycle 10 of a transfer aborts it
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
        wr(2'd0, 32'h0020_0001);
        wr(2'd1, 32'h0000_00A5);
        check("abort_busy_pre", 32'(busy), 32'd1);
        repeat (9) cyc();
        rst_n = 1'b0;
        cyc();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cs", 32'(spi_cs_n), 32'hF);
        check("abort_sclk", 32'(spi_clk), 32'd0);
        rd(2'd2, 1'b0, d); check("abort_rx", d, 32'd0);
        rd(2'd3, 1'b0, d); check("abort_status", d, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Mode 1, div=0, out-of-range cs_idx=5: no CS, transfer still runs
        wr(2'd0, 32'h0052_0000);
        run(8'h96, 4'hF, 0, 0, n, pulses, cs_ok);
        check("m1_busy_len", 32'(n), 32'd18);
        check("m1_no_cs", 32'(cs_ok), 32'd1);
        check("m1_pulses", 32'(pulses), 32'd8);
        rd(2'd2, 1'b0, d); check("m1_rx", d, 32'h96);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
